// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, NOP encoding, default boot address and fetch states.
package cpu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order queue of {pc, inst} between instruction memory and decode.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [2*XLEN-1:0] push_data,
    output logic [2*XLEN-1:0] head_data,
    output logic              full,
    output logic              empty
);

    logic [2*XLEN-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count == 2'd0);
    assign full      = (count == 2'd2);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer feeding decode through a 2-entry FIFO.
// Optional FETCH_MISALIGN_CHK_EN: a redirect to a non-word-aligned target halts fetch until reset.
//
// state | meaning
// BOOT  | single idle cycle after reset release, no request
// RUN   | issue reads while FIFO + in-flight stays below 2, honour redirects
// HALT  | misaligned redirect seen, no requests until reset
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4,
    output logic            misalign
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inflight_pc;
    logic [XLEN-1:0]   redirect_tgt;
    logic [XLEN-1:0]   head_pc;
    logic [XLEN-1:0]   head_inst;
    logic [2*XLEN-1:0] head_data;
    logic              inflight;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              flush;
    logic              req;
    logic              bad_target;
    logic [1:0]        occupancy;
    logic [2:0]        demand;

    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
    assign bad_target = |redirect_pc[1:0];
    assign misalign   = (state == HALT);
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign bad_target    = 1'b0;
    assign misalign      = 1'b0;
`endif

    assign occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign pop       = out_valid & out_ready;
    // Slots already committed after this cycle's transfer; a new read fits only below 2.
    assign demand    = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req        = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (bad_target) begin
                        state_next = HALT;
                    end
                end else begin
                    push = inflight;
                    req  = (demand < 3'd2);
                end
            end
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= req;
            if (req) begin
                inflight_pc <= pc;
            end
            if ((state == RUN) && redirect) begin
                pc <= redirect_tgt;
            end else if (req) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data ({inflight_pc, imem_rdata}),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_pc   = head_data[2*XLEN-1:XLEN];
    assign head_inst = head_data[XLEN-1:0];

    assign imem_req  = req;
    assign imem_addr = pc;
    assign out_valid = ~fifo_empty;
    assign out_inst  = out_valid ? head_inst : NOP_INST;
    assign out_pc    = out_valid ? head_pc : '0;
    assign out_pc4   = out_valid ? head_pc + XLEN'(4) : '0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction-memory read strobe.
REQ-005 SHALL have port imem_addr, output, 32 bits: word address for the read.
REQ-006 SHALL have port imem_rdata, input, 32 bits: read data, valid exactly one cycle after imem_req=1.
REQ-007 SHALL have port redirect, input, 1 bit: taken jump or branch from decode (npc_op=1).
REQ-008 SHALL have port redirect_pc, input, 32 bits: jump or branch target.
REQ-009 SHALL have port out_valid, output, 1 bit: instruction available to decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts this cycle.
REQ-011 SHALL have port out_inst, output, 32 bits: instruction word.
REQ-012 SHALL have port out_pc, output, 32 bits: PC of out_inst.
REQ-013 SHALL have port out_pc4, output, 32 bits: out_pc+4, used for the jal/jalr writeback.
REQ-014 SHALL have port misalign, output, 1 bit: sticky misaligned-target flag.

Function
REQ-015 FSM states SHALL be BOOT, RUN and HALT; BOOT lasts exactly one cycle after rst_n deasserts and issues no request, then moves to RUN.
REQ-016 In RUN, imem_req SHALL be 1 when occupancy + inflight - pop < 2, where pop = out_valid & out_ready and redirect = 0.
REQ-017 Issue SHALL drive imem_addr=pc and update pc <= pc+4, with 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).
REQ-018 Returned imem_rdata SHALL be written, with its PC, into a 2-entry in-order FIFO on the edge after the data cycle; fetch-to-out_valid latency is 2 cycles.
REQ-019 Transfer SHALL occur only when out_valid & out_ready; out_valid SHALL stay high and out_* SHALL stay stable until the transfer occurs.
REQ-020 With out_valid=0, out_inst SHALL be the NOP 32'h0000_0013.
REQ-021 With out_ready held at 1 and no redirect, the block SHALL sustain one instruction per cycle.
REQ-022 Redirect handling:
- pc <= redirect_pc; imem_req = 0 in the redirect cycle.
- Any in-flight response is discarded.
- All FIFO entries not transferred in that cycle are flushed.
- A transfer handshaking in the redirect cycle completes.
- First new out_valid occurs at cycle R+3.
REQ-023 When the FIFO is full and out_ready=0, the block SHALL issue no requests and drop no data.
REQ-024 A redirect arriving while the FIFO is full SHALL take priority and flush the FIFO.

Reset
REQ-025 rst_n=0 SHALL asynchronously force:
- state = BOOT, pc = RESET_PC.
- FIFO empty, inflight = 0.
- imem_req = 0, imem_addr = RESET_PC.
- out_valid = 0, out_inst = NOP, out_pc = 0, out_pc4 = 0, misalign = 0.
REQ-026 Reset asserted mid-fetch SHALL discard the in-flight read; the first fetch after release SHALL target RESET_PC.

Configuration
REQ-027 With FETCH_MISALIGN_CHK_EN defined, redirect with redirect_pc[1:0] != 0 SHALL:
- set misalign=1;
- enter HALT, flush the FIFO and issue no further requests;
- remain in HALT until reset.
REQ-028 Without FETCH_MISALIGN_CHK_EN, redirect_pc[1:0] SHALL be treated as 2'b00, misalign SHALL be tied 0, and HALT SHALL be unreachable.

Structure
REQ-029 Shared package cpu_pkg SHALL hold:
- XLEN=32;
- NOP_INST = 32'h0000_0013;
- DEFAULT_RESET_PC;
- the fetch state enum {BOOT, RUN, HALT}.
REQ-030 The 2-entry FIFO SHALL be a sub-module fetch_fifo (push, pop, flush, full, empty, 64-bit {pc, inst} payload).

Verification
REQ-031 Reset release with RESET_PC=0, out_ready=1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; out_valid first at cycle 3 with out_pc=0x0 and out_pc4=0x4.
REQ-032 out_ready=0 for 5 cycles mid-stream -> at most 2 requests issued, FIFO full, out_* stable; out_ready=1 afterwards -> PCs in order, no loss or duplicate.
REQ-033 redirect=1 with redirect_pc=0x0000_0100 while FIFO holds 2 entries -> both flushed, next imem_addr=0x100, next out_pc=0x100, no stale instruction delivered.
REQ-034 pc=0xFFFF_FFFC -> following imem_addr=0x0000_0000.
REQ-035 With FETCH_MISALIGN_CHK_EN: redirect_pc=0x0000_0102 -> misalign=1, imem_req=0 forever; rst_n pulse -> misalign=0 and fetch resumes at RESET_PC. Without the macro: next imem_addr=0x0000_0100.
REQ-036 rst_n asserted one cycle after a request -> the returned data is never delivered; after release the first out_pc=RESET_PC.
